// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter: round-robin grant, bus lock for the whole CYC,
// and a per-transfer watchdog that forces ERR when the slave never answers a strobe.
module wb_rr_arbiter #(
    parameter  int unsigned N_MASTER = 2,
    parameter  int unsigned DW       = 32,
    parameter  int unsigned AW       = 32,
    parameter  int unsigned TIMEOUT  = 255,
    localparam int unsigned SW       = DW / 8,
    localparam int unsigned GW       = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_MASTER-1:0]    m_cyc_i,
    input  logic [N_MASTER-1:0]    m_stb_i,
    input  logic [N_MASTER-1:0]    m_we_i,
    input  logic [N_MASTER*SW-1:0] m_sel_i,
    input  logic [N_MASTER*AW-1:0] m_adr_i,
    input  logic [N_MASTER*DW-1:0] m_dat_i,
    output logic [DW-1:0]          m_dat_o,
    output logic [N_MASTER-1:0]    m_ack_o,
    output logic [N_MASTER-1:0]    m_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [SW-1:0]          s_sel_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    input  logic [DW-1:0]          s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic [GW-1:0]          grant_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_next_grant;
    logic [GW-1:0] w_cand;
    logic          w_found;
    logic [TW-1:0] r_wdog;
    logic [TW-1:0] w_wdog_nxt;
    logic          w_owned;
    logic          w_g_cyc;
    logic          w_stb_fwd;
    logic          w_no_resp;
    logic          w_fire;

    assign w_owned   = (r_state == S_OWNED);
    assign w_g_cyc   = m_cyc_i[r_grant];
    assign w_stb_fwd = w_owned && w_g_cyc && m_stb_i[r_grant];
    assign w_no_resp = !s_ack_i && !s_err_i;
    // Watchdog fires only on a strobe still unanswered in this very cycle; a late ACK wins.
    assign w_fire    = (TIMEOUT != 0) && w_stb_fwd && w_no_resp && (r_wdog == TW'(TIMEOUT - 1));

    assign m_dat_o   = s_dat_i;
    assign grant_o   = r_grant;
    assign busy_o    = w_owned;
    assign timeout_o = w_fire;

    // State, grant pointers and watchdog registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= GW'(N_MASTER - 1);
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wdog  <= w_wdog_nxt;
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_next_grant;
                r_last  <= w_next_grant;
            end
        end
    end

    // Next state: round-robin scan starting after the last owner, plus watchdog count
    always_comb begin
        w_state_nxt  = r_state;
        w_wdog_nxt   = '0;
        w_next_grant = r_last;
        w_cand       = '0;
        w_found      = 1'b0;
        for (int unsigned i = 1; i <= N_MASTER; i++) begin
            w_cand = GW'((32'(r_last) + i) % N_MASTER);
            if (!w_found && m_cyc_i[w_cand]) begin
                w_found      = 1'b1;
                w_next_grant = w_cand;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_OWNED;
            end
            S_OWNED: begin
                if (!w_g_cyc) begin
                    w_state_nxt = S_IDLE;
                end else if ((TIMEOUT != 0) && w_stb_fwd && w_no_resp && !w_fire) begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: forward the owner's request and route responses back only to it
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (w_owned) begin
            s_cyc_o          = w_g_cyc;
            s_stb_o          = w_stb_fwd && !w_fire;
            s_we_o           = m_we_i[r_grant];
            s_sel_o          = m_sel_i[r_grant*SW +: SW];
            s_adr_o          = m_adr_i[r_grant*AW +: AW];
            s_dat_o          = m_dat_i[r_grant*DW +: DW];
            m_ack_o[r_grant] = s_ack_i;
            m_err_o[r_grant] = s_err_i || w_fire;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a 2-master instance with a short watchdog and a
// 4-master instance for round-robin fairness, each checked against hand-computed values.
module tb_wb_rr_arbiter;

    logic clk;
    logic rst;

    // Instance A: N_MASTER=2, TIMEOUT=4
    logic [1:0]  a_cyc, a_stb, a_we;
    logic [7:0]  a_sel;
    logic [63:0] a_adr, a_dat;
    logic [31:0] a_sdat;
    logic        a_ack, a_err;
    logic [31:0] a_mdat;
    logic [1:0]  a_mack, a_merr;
    logic        a_scyc, a_sstb, a_swe;
    logic [3:0]  a_ssel;
    logic [31:0] a_sadr, a_sdato;
    logic [0:0]  a_grant;
    logic        a_busy, a_to;

    // Instance B: N_MASTER=4, TIMEOUT=255
    logic [3:0]   b_cyc, b_stb, b_we;
    logic [15:0]  b_sel;
    logic [127:0] b_adr, b_dat;
    logic [31:0]  b_sdat;
    logic         b_ack, b_err;
    logic [31:0]  b_mdat;
    logic [3:0]   b_mack, b_merr;
    logic         b_scyc, b_sstb, b_swe;
    logic [3:0]   b_ssel;
    logic [31:0]  b_sadr, b_sdato;
    logic [1:0]   b_grant;
    logic         b_busy, b_to;

    int n_pass;
    int n_total;

    wb_rr_arbiter #(.N_MASTER(2), .DW(32), .AW(32), .TIMEOUT(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_sel_i(a_sel),
        .m_adr_i(a_adr), .m_dat_i(a_dat), .m_dat_o(a_mdat),
        .m_ack_o(a_mack), .m_err_o(a_merr),
        .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe), .s_sel_o(a_ssel),
        .s_adr_o(a_sadr), .s_dat_o(a_sdato), .s_dat_i(a_sdat),
        .s_ack_i(a_ack), .s_err_i(a_err),
        .grant_o(a_grant), .busy_o(a_busy), .timeout_o(a_to)
    );

    wb_rr_arbiter #(.N_MASTER(4), .DW(32), .AW(32), .TIMEOUT(255)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_sel_i(b_sel),
        .m_adr_i(b_adr), .m_dat_i(b_dat), .m_dat_o(b_mdat),
        .m_ack_o(b_mack), .m_err_o(b_merr),
        .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe), .s_sel_o(b_ssel),
        .s_adr_o(b_sadr), .s_dat_o(b_sdato), .s_dat_i(b_sdat),
        .s_ack_i(b_ack), .s_err_i(b_err),
        .grant_o(b_grant), .busy_o(b_busy), .timeout_o(b_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        n_pass = 0; n_total = 0;
        a_cyc = '0; a_stb = '0; a_we = '0; a_sel = '0; a_adr = '0; a_dat = '0;
        a_sdat = '0; a_ack = 1'b0; a_err = 1'b0;
        b_cyc = '0; b_stb = '0; b_we = '0; b_sel = '0; b_adr = '0; b_dat = '0;
        b_sdat = '0; b_ack = 1'b0; b_err = 1'b0;
        #2;
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_grant", 64'(a_grant), 64'd0);
        check("rst_scyc", 64'(a_scyc), 64'd0);
        check("rst_timeout", 64'(a_to), 64'd0);
        check("rst_mack", 64'(a_mack), 64'd0);
        tick();
        rst = 1'b0;

        // Single write from master 0
        a_cyc[0] = 1'b1; a_stb[0] = 1'b1; a_we[0] = 1'b1;
        a_adr[31:0] = 32'h10; a_dat[31:0] = 32'hDEADBEEF; a_sel[3:0] = 4'hF;
        #1;
        check("t1_latency", 64'(a_scyc), 64'd0);
        tick();
        check("t1_scyc", 64'(a_scyc), 64'd1);
        check("t1_sstb", 64'(a_sstb), 64'd1);
        check("t1_swe", 64'(a_swe), 64'd1);
        check("t1_sadr", 64'(a_sadr), 64'h10);
        check("t1_sdat", 64'(a_sdato), 64'hDEADBEEF);
        check("t1_ssel", 64'(a_ssel), 64'hF);
        check("t1_grant", 64'(a_grant), 64'd0);
        check("t1_noack", 64'(a_mack), 64'd0);
        tick();
        a_ack = 1'b1; #1;
        check("t1_ack", 64'(a_mack), 64'b01);
        check("t1_noerr", 64'(a_merr), 64'd0);
        tick();
        a_ack = 1'b0; a_cyc = '0; a_stb = '0; a_we = '0; #1;
        check("t1_release", 64'(a_scyc), 64'd0);
        tick();
        check("t1_idle", 64'(a_busy), 64'd0);
        a_sdat = 32'h12345678; a_ack = 1'b1; #1;
        check("idle_ack_drop", 64'(a_mack), 64'd0);
        check("rdata_pass", 64'(a_mdat), 64'h12345678);
        a_ack = 1'b0;

        // Two masters from reset alternate 0,1,0,1
        rst = 1'b1; #1; rst = 1'b0;
        a_cyc = 2'b11; a_stb = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_grant", 64'(a_grant), 64'(k % 2));
            check("t2_busy", 64'(a_busy), 64'd1);
            a_ack = 1'b1; #1;
            check("t2_ack", 64'(a_mack), 64'(1) << (k % 2));
            tick();
            a_ack = 1'b0; a_cyc[k % 2] = 1'b0; a_stb[k % 2] = 1'b0; #1;
            check("t2_release", 64'(a_scyc), 64'd0);
            tick();
            a_cyc[k % 2] = 1'b1; a_stb[k % 2] = 1'b1;
        end
        a_cyc = '0; a_stb = '0;
        tick();
        check("t2_idle", 64'(a_busy), 64'd0);

        // Master 0 locks the bus for three beats while master 1 waits
        a_cyc = 2'b11; a_stb = 2'b11;
        tick();
        for (int b = 0; b < 3; b++) begin
            a_ack = 1'b1; a_sdat = 32'hA0 + 32'(b); #1;
            check("t4_grant", 64'(a_grant), 64'd0);
            check("t4_ack", 64'(a_mack), 64'b01);
            check("t4_rdata", 64'(a_mdat), 64'(32'hA0 + 32'(b)));
            tick();
        end
        a_ack = 1'b0; a_cyc[0] = 1'b0; a_stb[0] = 1'b0; #1;
        check("t4_rel_noack", 64'(a_mack), 64'd0);
        check("t4_rel_scyc", 64'(a_scyc), 64'd0);
        tick();
        check("t4_gap_idle", 64'(a_busy), 64'd0);
        tick();
        check("t4_grant1", 64'(a_grant), 64'd1);
        a_ack = 1'b1; #1;
        check("t4_ack1", 64'(a_mack), 64'b10);
        tick();
        a_ack = 1'b0; a_cyc = '0; a_stb = '0;
        tick();

        // Watchdog with TIMEOUT=4: fires on the fourth unanswered strobe cycle
        a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            check("t5_wait_to", 64'(a_to), 64'd0);
            check("t5_wait_err", 64'(a_merr), 64'd0);
            tick();
        end
        check("t5_fire_to", 64'(a_to), 64'd1);
        check("t5_fire_err", 64'(a_merr), 64'b01);
        check("t5_fire_stb", 64'(a_sstb), 64'd0);
        check("t5_fire_cyc", 64'(a_scyc), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_rearm_to", 64'(a_to), 64'd0);
            check("t5_rearm_grant", 64'(a_grant), 64'd0);
        end
        tick();
        a_ack = 1'b1; #1;
        check("t5_ackwin_ack", 64'(a_mack), 64'b01);
        check("t5_ackwin_to", 64'(a_to), 64'd0);
        check("t5_ackwin_err", 64'(a_merr), 64'd0);
        tick();
        a_err = 1'b1; #1;
        check("t5_both_ack", 64'(a_mack), 64'b01);
        check("t5_both_err", 64'(a_merr), 64'b01);
        tick();
        a_ack = 1'b0; a_err = 1'b0; a_cyc = '0; a_stb = '0;
        tick();

        // Reset in the middle of a master-1 transfer
        a_cyc = 2'b10; a_stb = 2'b10;
        tick();
        check("t6_grant1", 64'(a_grant), 64'd1);
        a_ack = 1'b1; #1;
        check("t6_ack", 64'(a_mack), 64'b10);
        rst = 1'b1; #1;
        check("t6_scyc", 64'(a_scyc), 64'd0);
        check("t6_sstb", 64'(a_sstb), 64'd0);
        check("t6_mack", 64'(a_mack), 64'd0);
        check("t6_merr", 64'(a_merr), 64'd0);
        check("t6_busy", 64'(a_busy), 64'd0);
        tick();
        rst = 1'b0; a_ack = 1'b0; a_cyc = 2'b11; a_stb = 2'b11;
        tick();
        check("t6_prio0", 64'(a_grant), 64'd0);
        a_cyc = '0; a_stb = '0;
        tick();

        // Four masters, 1..3 always requesting: grant order 1,2,3,1,2,3
        b_cyc = 4'b1110; b_stb = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t3_grant", 64'(b_grant), 64'(1 + k % 3));
            b_ack = 1'b1; #1;
            check("t3_ack", 64'(b_mack), 64'(1) << (1 + k % 3));
            tick();
            b_ack = 1'b0; b_cyc[1 + k % 3] = 1'b0; b_stb[1 + k % 3] = 1'b0; #1;
            check("t3_release", 64'(b_scyc), 64'd0);
            tick();
            b_cyc[1 + k % 3] = 1'b1; b_stb[1 + k % 3] = 1'b1;
        end
        b_cyc = '0; b_stb = '0;
        tick();
        check("t3_idle", 64'(b_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
